// File: rtl/mag_sq_peak.sv
// Magnitude-squared stage with per-frame peak tracking.
// Turns signed 12-bit I/Q FFT bins into a saturated 23-bit I^2+Q^2 word for the
// square-root stage, numbers the bins, reports the strongest eligible bin of
// every complete frame and forwards the accumulated block delay.
module mag_sq_peak #(
    parameter int C_FFT_N    = 1024,
    parameter int C_BIN_W    = 10,
    parameter int C_BIN_MIN  = 1,
    parameter int C_DAT_DLYs = 3
) (
    input  logic                      CK_i,
    input  logic                      XARST_i,
    input  logic                      EN_i,
    input  logic                      SOF_i,
    input  logic signed [11:0]        Is_i,
    input  logic signed [11:0]        Qs_i,
    input  logic        [7:0]         B_IN_DAT_DLYs_i,
    output logic        [22:0]        DATs_o,
    output logic                      DAT_EN_o,
    output logic                      DAT_SOF_o,
    output logic        [C_BIN_W-1:0] BINs_o,
    output logic        [22:0]        PEAKs_o,
    output logic        [C_BIN_W-1:0] PEAK_BINs_o,
    output logic                      PEAK_EN_o,
    output logic        [7:0]         B_OUT_DAT_DLYs_o
);

    localparam logic [C_BIN_W-1:0] LAST_BIN = C_BIN_W'(C_FFT_N - 1);
    localparam logic [C_BIN_W-1:0] MIN_BIN  = C_BIN_W'(C_BIN_MIN);
    localparam logic [22:0]        SAT_MAX  = 23'h7F_FFFF;

    // Stage 1 registers
    logic signed [11:0] s1I_q, s1Q_q;
    logic               s1En_q, s1Sof_q;

    // Stage 2 registers and their next-state squares
    logic [22:0]        s2ISq_q, s2QSq_q;
    logic [22:0]        s2ISq_d, s2QSq_d;
    logic               s2En_q, s2Sof_q;
    logic signed [22:0] iExt, qExt;

    // Stage 3 / output-domain state
    logic [23:0]        sumD;
    logic [22:0]        satD;
    logic [C_BIN_W-1:0] curBin;
    logic [22:0]        dat_q, dat_d;
    logic               datEn_q, datEn_d;
    logic               datSof_q, datSof_d;
    logic [C_BIN_W-1:0] bin_q, bin_d;
    logic [C_BIN_W-1:0] nextBin_q, nextBin_d;
    logic               active_q, active_d;
    logic [22:0]        candVal_q, candVal_d;
    logic [C_BIN_W-1:0] candBin_q, candBin_d;
    logic               lastSeen_q, lastSeen_d;
    logic [22:0]        peak_q, peak_d;
    logic [C_BIN_W-1:0] peakBin_q, peakBin_d;
    logic               peakEn_q, peakEn_d;

    // Delay bookkeeping is pure arithmetic and wraps naturally at 8 bits.
    assign B_OUT_DAT_DLYs_o = B_IN_DAT_DLYs_i + 8'(C_DAT_DLYs);

    // Stage 1: capture the raw sample together with its qualifiers.
    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            s1I_q   <= '0;
            s1Q_q   <= '0;
            s1En_q  <= 1'b0;
            s1Sof_q <= 1'b0;
        end else begin
            s1I_q   <= Is_i;
            s1Q_q   <= Qs_i;
            s1En_q  <= EN_i;
            s1Sof_q <= SOF_i;
        end
    end

    // A square of a 12-bit signed value is at most 2**22, so 23 bits hold it exactly.
    assign iExt    = {{11{s1I_q[11]}}, s1I_q};
    assign qExt    = {{11{s1Q_q[11]}}, s1Q_q};
    assign s2ISq_d = 23'(iExt * iExt);
    assign s2QSq_d = 23'(qExt * qExt);

    // Stage 2: register the two squares.
    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            s2ISq_q <= '0;
            s2QSq_q <= '0;
            s2En_q  <= 1'b0;
            s2Sof_q <= 1'b0;
        end else begin
            s2ISq_q <= s2ISq_d;
            s2QSq_q <= s2QSq_d;
            s2En_q  <= s1En_q;
            s2Sof_q <= s1Sof_q;
        end
    end

    // Only -2048/-2048 can overflow 23 bits; clamp it to full scale.
    assign sumD = {1'b0, s2ISq_q} + {1'b0, s2QSq_q};
    assign satD = sumD[23] ? SAT_MAX : sumD[22:0];

    // A real SOF forces bin 0; otherwise the sample takes the pending bin number.
    assign curBin = s2Sof_q ? '0 : nextBin_q;

    // Stage 3 next-state: output word, bin numbering, peak candidate and strobe.
    always_comb begin
        dat_d      = dat_q;
        datEn_d    = s2En_q;
        datSof_d   = s2En_q & s2Sof_q;
        bin_d      = bin_q;
        nextBin_d  = nextBin_q;
        active_d   = active_q;
        candVal_d  = candVal_q;
        candBin_d  = candBin_q;
        lastSeen_d = 1'b0;
        peak_d     = peak_q;
        peakBin_d  = peakBin_q;
        peakEn_d   = 1'b0;

        if (s2En_q) begin
            dat_d     = satD;
            bin_d     = curBin;
            nextBin_d = (curBin == LAST_BIN) ? '0 : curBin + C_BIN_W'(1);
            if (s2Sof_q) begin
                active_d = 1'b1;
            end
            if (curBin == '0) begin
                candVal_d = (C_BIN_MIN == 0) ? satD : '0;
                candBin_d = '0;
            end else if ((curBin >= MIN_BIN) && (satD > candVal_q)) begin
                candVal_d = satD;
                candBin_d = curBin;
            end
            lastSeen_d = (curBin == LAST_BIN) && active_d;
        end

        if (lastSeen_q) begin
            peak_d    = candVal_q;
            peakBin_d = candBin_q;
            peakEn_d  = 1'b1;
        end
    end

    // Stage 3 state register; reset discards any partially observed frame.
    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            dat_q      <= '0;
            datEn_q    <= 1'b0;
            datSof_q   <= 1'b0;
            bin_q      <= '0;
            nextBin_q  <= '0;
            active_q   <= 1'b0;
            candVal_q  <= '0;
            candBin_q  <= '0;
            lastSeen_q <= 1'b0;
            peak_q     <= '0;
            peakBin_q  <= '0;
            peakEn_q   <= 1'b0;
        end else begin
            dat_q      <= dat_d;
            datEn_q    <= datEn_d;
            datSof_q   <= datSof_d;
            bin_q      <= bin_d;
            nextBin_q  <= nextBin_d;
            active_q   <= active_d;
            candVal_q  <= candVal_d;
            candBin_q  <= candBin_d;
            lastSeen_q <= lastSeen_d;
            peak_q     <= peak_d;
            peakBin_q  <= peakBin_d;
            peakEn_q   <= peakEn_d;
        end
    end

    assign DATs_o      = dat_q;
    assign DAT_EN_o    = datEn_q;
    assign DAT_SOF_o   = datSof_q;
    assign BINs_o      = bin_q;
    assign PEAKs_o     = peak_q;
    assign PEAK_BINs_o = peakBin_q;
    assign PEAK_EN_o   = peakEn_q;

endmodule

// File: tb/tb_mag_sq_peak.sv
// Directed testbench for mag_sq_peak built with a 16-bin frame.
module tb_mag_sq_peak;

    localparam int N = 16;
    localparam int W = 4;

    logic               CK_i = 1'b0;
    logic               XARST_i = 1'b0;
    logic               EN_i = 1'b0;
    logic               SOF_i = 1'b0;
    logic signed [11:0] Is_i = '0;
    logic signed [11:0] Qs_i = '0;
    logic [7:0]         B_IN_DAT_DLYs_i = '0;
    logic [22:0]        DATs_o;
    logic               DAT_EN_o;
    logic               DAT_SOF_o;
    logic [W-1:0]       BINs_o;
    logic [22:0]        PEAKs_o;
    logic [W-1:0]       PEAK_BINs_o;
    logic               PEAK_EN_o;
    logic [7:0]         B_OUT_DAT_DLYs_o;

    mag_sq_peak #(
        .C_FFT_N   (N),
        .C_BIN_W   (W),
        .C_BIN_MIN (1),
        .C_DAT_DLYs(3)
    ) dut (
        .CK_i            (CK_i),
        .XARST_i         (XARST_i),
        .EN_i            (EN_i),
        .SOF_i           (SOF_i),
        .Is_i            (Is_i),
        .Qs_i            (Qs_i),
        .B_IN_DAT_DLYs_i (B_IN_DAT_DLYs_i),
        .DATs_o          (DATs_o),
        .DAT_EN_o        (DAT_EN_o),
        .DAT_SOF_o       (DAT_SOF_o),
        .BINs_o          (BINs_o),
        .PEAKs_o         (PEAKs_o),
        .PEAK_BINs_o     (PEAK_BINs_o),
        .PEAK_EN_o       (PEAK_EN_o),
        .B_OUT_DAT_DLYs_o(B_OUT_DAT_DLYs_o)
    );

    always #5 CK_i = ~CK_i;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int cur[N];
    int expA[N];

    int datQ[$];
    int binQ[$];
    int sofQ[$];
    int datCyc[$];
    int peakVal[$];
    int peakBin[$];
    int peakCyc[$];

    // Free-running cycle count used to time the peak strobe.
    always @(posedge CK_i) cycle <= cycle + 1;

    // Record every valid output word and every peak strobe mid-cycle.
    always @(negedge CK_i) begin
        if (DAT_EN_o) begin
            datQ.push_back(int'(DATs_o));
            binQ.push_back(int'(BINs_o));
            sofQ.push_back(int'(DAT_SOF_o));
            datCyc.push_back(cycle);
        end
        if (PEAK_EN_o) begin
            peakVal.push_back(int'(PEAKs_o));
            peakBin.push_back(int'(PEAK_BINs_o));
            peakCyc.push_back(cycle);
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit sof, input int i, input int q);
        EN_i  = en;
        SOF_i = sof;
        Is_i  = 12'(i);
        Qs_i  = 12'(q);
        @(posedge CK_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, 0);
    endtask

    task automatic clearMon();
        datQ.delete();
        binQ.delete();
        sofQ.delete();
        datCyc.delete();
        peakVal.delete();
        peakBin.delete();
        peakCyc.delete();
    endtask

    task automatic clearCur();
        for (int k = 0; k < N; k++) cur[k] = 0;
    endtask

    task automatic sendFrame(input bit gapped, input bit withSof, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            applyStimulus(1'b1, withSof && (k == first), cur[k], 0);
            if (gapped) applyStimulus(1'b0, 1'b0, 0, 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_dat"}, int'(DATs_o), 0);
        checkOutput({tag, "_en"}, int'(DAT_EN_o), 0);
        checkOutput({tag, "_sof"}, int'(DAT_SOF_o), 0);
        checkOutput({tag, "_bin"}, int'(BINs_o), 0);
        checkOutput({tag, "_peak"}, int'(PEAKs_o), 0);
        checkOutput({tag, "_pkbin"}, int'(PEAK_BINs_o), 0);
        checkOutput({tag, "_pken"}, int'(PEAK_EN_o), 0);
    endtask

    initial begin
        // Power-up reset
        idle(2);
        checkAllZero("rst");
        XARST_i = 1'b1;
        idle(1);

        // Delay forwarding, including wrap
        B_IN_DAT_DLYs_i = 8'd4;
        #1;
        checkOutput("dly_4", int'(B_OUT_DAT_DLYs_o), 7);
        B_IN_DAT_DLYs_i = 8'd254;
        #1;
        checkOutput("dly_wrap", int'(B_OUT_DAT_DLYs_o), 1);

        // Latency: 3^2 + 4^2 = 25 visible after the third edge
        applyStimulus(1'b1, 1'b0, 3, -4);
        checkOutput("lat_e1", int'(DAT_EN_o), 0);
        idle(1);
        checkOutput("lat_e2", int'(DAT_EN_o), 0);
        idle(1);
        checkOutput("lat_en", int'(DAT_EN_o), 1);
        checkOutput("lat_dat", int'(DATs_o), 25);
        checkOutput("lat_bin", int'(BINs_o), 0);
        checkOutput("lat_sof", int'(DAT_SOF_o), 0);
        idle(1);
        checkOutput("hold_en", int'(DAT_EN_o), 0);
        checkOutput("hold_dat", int'(DATs_o), 25);

        // Arithmetic extremes back to back
        applyStimulus(1'b1, 1'b0, 2047, -2047);
        applyStimulus(1'b1, 1'b0, -2048, -2048);
        applyStimulus(1'b1, 1'b0, -2048, 2047);
        checkOutput("ar_max", int'(DATs_o), 8380418);
        checkOutput("ar_bin1", int'(BINs_o), 1);
        idle(1);
        checkOutput("ar_sat", int'(DATs_o), 8388607);
        checkOutput("ar_bin2", int'(BINs_o), 2);
        idle(1);
        checkOutput("ar_mix", int'(DATs_o), 8384513);
        checkOutput("ar_bin3", int'(BINs_o), 3);
        idle(2);

        // Peak frame: DC excluded, tie keeps the lower bin
        clearMon();
        clearCur();
        cur[0] = 100;
        cur[5] = 40;
        cur[9] = 40;
        for (int k = 0; k < N; k++) expA[k] = cur[k] * cur[k];
        sendFrame(1'b0, 1'b1, 0, N - 1);
        idle(4);
        checkOutput("pk_cnt", datQ.size(), N);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("pk_dat%0d", k), datQ[k], expA[k]);
            checkOutput($sformatf("pk_bin%0d", k), binQ[k], k);
            checkOutput($sformatf("pk_sof%0d", k), sofQ[k], (k == 0) ? 1 : 0);
        end
        checkOutput("pk_strobes", peakVal.size(), 1);
        checkOutput("pk_val", peakVal[0], 1600);
        checkOutput("pk_idx", peakBin[0], 5);
        checkOutput("pk_timing", peakCyc[0], datCyc[N - 1] + 1);
        checkOutput("pk_hold", int'(PEAKs_o), 1600);
        checkOutput("pk_en_low", int'(PEAK_EN_o), 0);

        // Gapped input, then wrap into an implicit frame
        clearMon();
        sendFrame(1'b1, 1'b1, 0, N - 1);
        applyStimulus(1'b1, 1'b0, 5, 0);
        clearCur();
        cur[3]  = 7;
        cur[12] = -7;
        sendFrame(1'b0, 1'b0, 1, N - 1);
        idle(4);
        checkOutput("gap_cnt", datQ.size(), 2 * N);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("gap_dat%0d", k), datQ[k], expA[k]);
            checkOutput($sformatf("gap_bin%0d", k), binQ[k], k);
        end
        checkOutput("wrap_dat", datQ[N], 25);
        checkOutput("wrap_bin", binQ[N], 0);
        checkOutput("wrap_sof", sofQ[N], 0);
        checkOutput("wrap_strobes", peakVal.size(), 2);
        checkOutput("gap_pkval", peakVal[0], 1600);
        checkOutput("gap_pkidx", peakBin[0], 5);
        checkOutput("wrap_pkval", peakVal[1], 49);
        checkOutput("wrap_pkidx", peakBin[1], 3);

        // All-zero eligible data
        clearMon();
        clearCur();
        cur[0] = 100;
        sendFrame(1'b0, 1'b1, 0, N - 1);
        idle(4);
        checkOutput("zero_strobes", peakVal.size(), 1);
        checkOutput("zero_val", peakVal[0], 0);
        checkOutput("zero_idx", peakBin[0], 0);

        // Early SOF aborts a frame; last bin of the next frame wins
        clearMon();
        clearCur();
        cur[2] = 50;
        sendFrame(1'b0, 1'b1, 0, 6);
        clearCur();
        cur[10] = 29;
        cur[15] = -30;
        sendFrame(1'b0, 1'b1, 0, N - 1);
        idle(4);
        checkOutput("early_cnt", datQ.size(), 7 + N);
        checkOutput("early_bin", binQ[7], 0);
        checkOutput("early_sof", sofQ[7], 1);
        checkOutput("early_strobes", peakVal.size(), 1);
        checkOutput("early_val", peakVal[0], 900);
        checkOutput("early_idx", peakBin[0], 15);

        // Reset in the middle of a frame
        clearCur();
        cur[3] = 60;
        sendFrame(1'b0, 1'b1, 0, 7);
        XARST_i = 1'b0;
        idle(1);
        checkAllZero("midrst");
        XARST_i = 1'b1;
        clearMon();
        clearCur();
        cur[12] = 60;
        sendFrame(1'b0, 1'b0, 0, N - 1);
        idle(4);
        checkOutput("mr_cnt", datQ.size(), N);
        checkOutput("mr_bin0", binQ[0], 0);
        checkOutput("mr_bin15", binQ[N - 1], 15);
        checkOutput("mr_dat12", datQ[12], 3600);
        checkOutput("mr_strobes", peakVal.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
